produce_hit_scorer: RTL and testbench

- Downstream consumer of the produce vertical-motion stage.
- Each frame it takes the produce object's position and direction, together with the player hammer's position and strike button.
- Detects bounding-box collisions (hits) and objects that fall off the bottom unstruck (misses).
- Maintains score, lives and game-over, and sequences hide/respawn of the object back to the motion stage.

---
 rtl/produce_game_pkg.sv | 20 ++
 rtl/box_overlap.sv | 39 +++
 rtl/produce_hit_scorer.sv | 178 +++++++++++++++++
 tb/tb_produce_hit_scorer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/produce_game_pkg.sv
// Shared constants and types for the produce game pipeline.
//   Screen geometry, coordinate widths and the scorer state encoding.
package produce_game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned Y_TOP    = 180;
  localparam int unsigned Y_BOTTOM = 480;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    FLASH     = 2'd1,
    HIDDEN    = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned bounding-box overlap test between box A and box B.
//   a_x/a_y, b_x/b_y : top-left corners
//   overlap_c        : combinational, high when the open interiors intersect
// Right/bottom edges are formed one bit wider so they never wrap; strict
// compares mean boxes that only share an edge do not overlap.
module box_overlap #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9,
  parameter int unsigned A_W = 32,
  parameter int unsigned A_H = 32,
  parameter int unsigned B_W = 24,
  parameter int unsigned B_H = 24
) (
  input  logic [X_W-1:0] a_x,
  input  logic [Y_W-1:0] a_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  output logic           overlap_c
);

  logic [X_W:0] a_x_c, b_x_c, a_x_end_c, b_x_end_c;
  logic [Y_W:0] a_y_c, b_y_c, a_y_end_c, b_y_end_c;

  // Zero-extended corners and far edges.
  always_comb begin
    a_x_c     = {1'b0, a_x};
    b_x_c     = {1'b0, b_x};
    a_y_c     = {1'b0, a_y};
    b_y_c     = {1'b0, b_y};
    a_x_end_c = a_x_c + (X_W+1)'(A_W);
    b_x_end_c = b_x_c + (X_W+1)'(B_W);
    a_y_end_c = a_y_c + (Y_W+1)'(A_H);
    b_y_end_c = b_y_c + (Y_W+1)'(B_H);
  end

  assign overlap_c = (b_x_c < a_x_end_c) && (a_x_c < b_x_end_c) &&
                     (b_y_c < a_y_end_c) && (a_y_c < b_y_end_c);

endmodule

// File: rtl/produce_hit_scorer.sv
// Hit/miss scorer for one produce object.
//   Inputs : clock, resetn (sync, active-low), frame_tick, object position and
//            direction, hammer position and strike level, restart level.
//   Outputs: obj_visible, obj_flash, respawn_req, hit_pulse, miss_pulse,
//            score, lives, game_over -- all registered.
// Game state advances only on frame_tick; GAME_OVER watches restart every cycle.
module produce_hit_scorer
  import produce_game_pkg::*;
#(
  parameter int unsigned OBJ_W          = 32,
  parameter int unsigned OBJ_H          = 32,
  parameter int unsigned HAM_W          = 24,
  parameter int unsigned HAM_H          = 24,
  parameter int unsigned Y_BOTTOM       = produce_game_pkg::Y_BOTTOM,
  parameter int unsigned FLASH_FRAMES   = 8,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned SCORE_W        = 12,
  parameter int unsigned START_LIVES    = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     obj_x,
  input  logic [Y_W-1:0]     obj_y,
  input  logic               obj_dir_down,
  input  logic [X_W-1:0]     ham_x,
  input  logic [Y_W-1:0]     ham_y,
  input  logic               ham_strike,
  input  logic               restart,
  output logic               obj_visible,
  output logic               obj_flash,
  output logic               respawn_req,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               game_over
);

  localparam int unsigned CNT_MAX = (FLASH_FRAMES > RESPAWN_FRAMES) ? FLASH_FRAMES
                                                                     : RESPAWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic               obj_visible_q, obj_visible_d;
  logic               obj_flash_q, obj_flash_d;
  logic               respawn_q, respawn_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               game_over_q, game_over_d;

  logic overlap_c;
  logic hit_c;
  logic miss_c;

  box_overlap #(
    .X_W (X_W),
    .Y_W (Y_W),
    .A_W (OBJ_W),
    .A_H (OBJ_H),
    .B_W (HAM_W),
    .B_H (HAM_H)
  ) u_overlap (
    .a_x       (obj_x),
    .a_y       (obj_y),
    .b_x       (ham_x),
    .b_y       (ham_y),
    .overlap_c (overlap_c)
  );

  assign hit_c  = overlap_c && ham_strike;
  assign miss_c = obj_dir_down && ({1'b0, obj_y} > (Y_W+1)'(Y_BOTTOM));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_d   = score_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    case (state_q)
      ACTIVE: begin
        if (frame_tick) begin
          // A hit on the same tick as a fall-off takes priority.
          if (hit_c) begin
            score_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
            hit_d   = 1'b1;
            cnt_d   = '0;
            state_d = FLASH;
          end else if (miss_c) begin
            lives_d = lives_q - 4'd1;
            miss_d  = 1'b1;
            cnt_d   = '0;
            state_d = (lives_q == 4'd1) ? GAME_OVER : HIDDEN;
          end
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = HIDDEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HIDDEN: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
            cnt_d     = '0;
            respawn_d = 1'b1;
            state_d   = ACTIVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAME_OVER: begin
        if (restart) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          score_d = '0;
          lives_d = 4'(START_LIVES);
        end
      end
      default: state_d = ACTIVE;
    endcase

    // Draw/status flags follow the state being entered so they stay registered.
    obj_visible_d = (state_d == ACTIVE) || (state_d == FLASH);
    obj_flash_d   = (state_d == FLASH);
    game_over_d   = (state_d == GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ACTIVE;
      cnt_q         <= '0;
      score_q       <= '0;
      lives_q       <= 4'(START_LIVES);
      obj_visible_q <= 1'b1;
      obj_flash_q   <= 1'b0;
      respawn_q     <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      obj_visible_q <= obj_visible_d;
      obj_flash_q   <= obj_flash_d;
      respawn_q     <= respawn_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      game_over_q   <= game_over_d;
    end
  end

  assign obj_visible = obj_visible_q;
  assign obj_flash   = obj_flash_q;
  assign respawn_req = respawn_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_produce_hit_scorer.sv
// Scoreboard bench for produce_hit_scorer: directed stimulus pushes expected
// pulse events, a negedge monitor pops and compares whenever a pulse appears.
module tb_produce_hit_scorer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic [9:0]  obj_x;
  logic [8:0]  obj_y;
  logic        obj_dir_down;
  logic [9:0]  ham_x;
  logic [8:0]  ham_y;
  logic        ham_strike;
  logic        restart;
  logic        obj_visible, obj_flash, respawn_req, hit_pulse, miss_pulse, game_over;
  logic [11:0] score;
  logic [3:0]  lives;

  // Small-score instance for saturation.
  logic        s_tick;
  logic        s_visible, s_flash, s_respawn, s_hit, s_miss, s_game_over;
  logic [1:0]  s_score;
  logic [3:0]  s_lives;

  always #5 clock = ~clock;

  produce_hit_scorer dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_dir_down (obj_dir_down),
    .ham_x        (ham_x),
    .ham_y        (ham_y),
    .ham_strike   (ham_strike),
    .restart      (restart),
    .obj_visible  (obj_visible),
    .obj_flash    (obj_flash),
    .respawn_req  (respawn_req),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .score        (score),
    .lives        (lives),
    .game_over    (game_over)
  );

  produce_hit_scorer #(
    .SCORE_W        (2),
    .FLASH_FRAMES   (1),
    .RESPAWN_FRAMES (1)
  ) dut_sat (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (s_tick),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_dir_down (obj_dir_down),
    .ham_x        (ham_x),
    .ham_y        (ham_y),
    .ham_strike   (ham_strike),
    .restart      (1'b0),
    .obj_visible  (s_visible),
    .obj_flash    (s_flash),
    .respawn_req  (s_respawn),
    .hit_pulse    (s_hit),
    .miss_pulse   (s_miss),
    .score        (s_score),
    .lives        (s_lives),
    .game_over    (s_game_over)
  );

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic        resp;
    logic [11:0] score;
    logic [3:0]  lives;
    logic        vis;
    logic        flash;
    logic        go;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_exp;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic hit, input logic miss, input logic resp,
                      input logic [11:0] sc, input logic [3:0] lv,
                      input logic vis, input logic flash, input logic go);
    ev_t e;
    e = '{hit: hit, miss: miss, resp: resp, score: sc, lives: lv,
          vis: vis, flash: flash, go: go};
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the next expected event.
  always @(negedge clock) begin
    if (hit_pulse || miss_pulse || respawn_req) begin
      mon_got = '{hit: hit_pulse, miss: miss_pulse, resp: respawn_req, score: score,
                  lives: lives, vis: obj_visible, flash: obj_flash, go: game_over};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event at %0t: got %h expected none", $time, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL event at %0t: got %h expected %h", $time, mon_got, mon_exp);
        end
      end
    end
  end

  task automatic set_in(input int ox, input int oy, input logic dn,
                        input int hx, input int hy, input logic st);
    obj_x        = 10'(ox);
    obj_y        = 9'(oy);
    obj_dir_down = dn;
    ham_x        = 10'(hx);
    ham_y        = 9'(hy);
    ham_strike   = st;
  endtask

  task automatic neutral();
    set_in(100, 200, 1'b0, 400, 10, 1'b0);
  endtask

  // One frame tick; called and returns at a negedge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic hidden_recover(input logic [11:0] sc, input logic [3:0] lv);
    repeat (29) tick();
    check("no_early_respawn", 32'(respawn_req), 0);
    push(1'b0, 1'b0, 1'b1, sc, lv, 1'b1, 1'b0, 1'b0);
    tick();
    neutral();
  endtask

  // FLASH then HIDDEN with the hammer still striking; nothing may score.
  task automatic recover(input logic [11:0] sc, input logic [3:0] lv);
    set_in(100, 200, 1'b0, 110, 210, 1'b1);
    repeat (7) tick();
    check("flash_held", {30'd0, obj_visible, obj_flash}, 32'd3);
    tick();
    check("hidden_after_flash", {30'd0, obj_visible, obj_flash}, 32'd0);
    hidden_recover(sc, lv);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_lives"}, 32'(lives), 3);
    check({tag, "_flags"}, {26'd0, obj_visible, obj_flash, game_over,
                            hit_pulse, miss_pulse, respawn_req}, 32'b100000);
  endtask

  initial begin
    logic [1:0] sat_exp [4];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    resetn = 1'b0; frame_tick = 1'b0; restart = 1'b0; s_tick = 1'b0;
    neutral();
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Basic hit, flash, hide, respawn.
    set_in(100, 200, 1'b0, 110, 210, 1'b1);
    push(1'b1, 1'b0, 1'b0, 12'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    neutral();
    recover(12'd1, 4'd3);

    // Touching edges never hit; non-strike overlap never hits.
    set_in(100, 200, 1'b0, 132, 210, 1'b1); tick();
    check("edge_right", 32'(score), 1);
    set_in(100, 200, 1'b0, 76, 210, 1'b1); tick();
    check("edge_left", 32'(score), 1);
    set_in(100, 200, 1'b0, 110, 232, 1'b1); tick();
    check("edge_bottom", 32'(score), 1);
    set_in(100, 200, 1'b0, 110, 176, 1'b1); tick();
    check("edge_top", 32'(score), 1);
    set_in(100, 200, 1'b0, 110, 210, 1'b0); tick();
    check("no_strike", 32'(score), 1);

    // restart outside GAME_OVER is ignored.
    neutral();
    restart = 1'b1;
    repeat (2) @(negedge clock);
    restart = 1'b0;
    check("restart_ignored", {score, lives}, {12'd1, 4'd3});

    set_in(100, 200, 1'b0, 131, 210, 1'b1);
    push(1'b1, 1'b0, 1'b0, 12'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    neutral();
    recover(12'd2, 4'd3);

    // Hit and fall-off on the same tick: hit wins.
    set_in(100, 485, 1'b1, 110, 490, 1'b1);
    push(1'b1, 1'b0, 1'b0, 12'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    neutral();
    recover(12'd3, 4'd3);

    // Miss boundaries, then three misses to game over.
    set_in(100, 480, 1'b1, 400, 10, 1'b0); tick();
    check("miss_at_480", 32'(lives), 3);
    set_in(100, 481, 1'b0, 400, 10, 1'b0); tick();
    check("miss_going_up", 32'(lives), 3);
    set_in(100, 481, 1'b1, 400, 10, 1'b0);
    push(1'b0, 1'b1, 1'b0, 12'd3, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    neutral();
    hidden_recover(12'd3, 4'd2);
    set_in(100, 481, 1'b1, 400, 10, 1'b0);
    push(1'b0, 1'b1, 1'b0, 12'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    neutral();
    hidden_recover(12'd3, 4'd1);
    set_in(100, 481, 1'b1, 400, 10, 1'b0);
    push(1'b0, 1'b1, 1'b0, 12'd3, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // GAME_OVER ignores hits and misses.
    set_in(100, 200, 1'b0, 110, 210, 1'b1);
    repeat (5) tick();
    set_in(100, 481, 1'b1, 400, 10, 1'b0);
    repeat (3) tick();
    check("go_frozen", {score, lives}, {12'd3, 4'd0});
    check("go_flags", {29'd0, obj_visible, obj_flash, game_over}, 32'b001);

    neutral();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check_reset_vals("restart");

    // Strike held across non-tick cycles: one hit per tick only.
    set_in(100, 200, 1'b0, 110, 210, 1'b1);
    repeat (5) @(negedge clock);
    push(1'b1, 1'b0, 1'b0, 12'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    repeat (5) @(negedge clock);
    check("held_one_hit", 32'(score), 1);
    repeat (7) tick();
    tick();
    check("hidden_before_reset", 32'(obj_visible), 0);
    repeat (5) tick();

    // Reset mid-HIDDEN drops the pending respawn.
    resetn = 1'b0;
    @(negedge clock);
    check_reset_vals("mid_reset");
    resetn = 1'b1;
    neutral();
    repeat (40) tick();
    check("post_reset_visible", 32'(obj_visible), 1);

    // Score saturation on the 2-bit instance.
    for (int k = 0; k < 4; k++) begin
      set_in(100, 200, 1'b0, 110, 210, 1'b1);
      s_tick = 1'b1;
      @(negedge clock);
      s_tick = 1'b0;
      check("sat_hit_pulse", 32'(s_hit), 1);
      check("sat_score", 32'(s_score), 32'(sat_exp[k]));
      neutral();
      s_tick = 1'b1;
      repeat (2) @(negedge clock);
      s_tick = 1'b0;
      check("sat_respawn", 32'(s_respawn), 1);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
